// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, board geometry and pipeline types
package vga_pkg;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_MAX   = H_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_MAX   = V_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int N_TILES = 4;
  localparam int EXP_W   = 4;

  typedef struct packed {
    logic [EXP_W-1:0] code;
    logic             in_board;
    logic             visible;
    logic             hs_n;
    logic             vs_n;
  } stage1_t;

  localparam stage1_t STAGE1_RST = '{code: '0, in_board: 1'b0, visible: 1'b0,
                                     hs_n: 1'b1, vs_n: 1'b1};

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-clock divider and 640x480@60 h/v scan counters
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs_n,
  output logic       vs_n,
  output logic       visible
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;

  always_comb begin
    pix_en = (div_q == DIV_MAX);
    div_d  = pix_en ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign h       = h_q;
  assign v       = v_q;
  assign hs_n    = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign vs_n    = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  assign visible = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - 4x4 tile board scan-out: ROM addressing, tile select and VGA pins
module tile_renderer
  import vga_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter int          BOARD_X0   = 120,
  parameter int          BOARD_Y0   = 40,
  parameter int          TILE       = 100,
  parameter logic [11:0] BORDER_RGB = 12'h333
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] board,
  input  logic [11:0] signal0,
  input  logic [11:0] signal1,
  input  logic [11:0] signal2,
  input  logic [11:0] signal3,
  input  logic [11:0] signal4,
  input  logic [11:0] signal5,
  input  logic [11:0] signal6,
  input  logic [11:0] signal7,
  input  logic [11:0] signal8,
  input  logic [11:0] signal9,
  input  logic [11:0] signal10,
  input  logic [11:0] signal11,
  output logic [18:0] pixel_addr,
  output logic [11:0] vga_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam logic [9:0] X0   = 10'(BOARD_X0);
  localparam logic [9:0] X0M1 = 10'(BOARD_X0 - 1);
  localparam logic [9:0] X1   = 10'(BOARD_X0 + N_TILES * TILE);
  localparam logic [9:0] Y0   = 10'(BOARD_Y0);
  localparam logic [9:0] Y0M1 = 10'(BOARD_Y0 - 1);
  localparam logic [9:0] Y1   = 10'(BOARD_Y0 + N_TILES * TILE);
  localparam logic [6:0] T_MAX = 7'(TILE - 1);

  logic       pix_en, hs_n, vs_n, visible;
  logic [9:0] h, v;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk     (clk),
    .rst     (rst),
    .pix_en  (pix_en),
    .h       (h),
    .v       (v),
    .hs_n    (hs_n),
    .vs_n    (vs_n),
    .visible (visible)
  );

  logic [6:0]  tx_q, tx_d, ty_q, ty_d;
  logic [1:0]  col_q, col_d, row_q, row_d;
  logic [63:0] shadow_q, shadow_d;
  logic        frame_start_q, frame_start_d;
  stage1_t     s1_q, s1_d;
  logic [18:0] addr_q, addr_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        h_wrap, in_board;
  logic [3:0]  tile_idx;
  logic [18:0] row_base;
  logic [11:0] tile_pix;

  always_comb begin
    h_wrap   = pix_en && (h == H_MAX);
    in_board = (h >= X0) && (h < X1) && (v >= Y0) && (v < Y1);
    tile_idx = {row_q, col_q};
    // ty*100 as ty*64 + ty*32 + ty*4
    row_base = 19'({ty_q, 6'b0}) + 19'({ty_q, 5'b0}) + 19'({ty_q, 2'b0});

    tx_d  = tx_q;
    col_d = col_q;
    if (pix_en) begin
      if (h == X0M1) begin
        tx_d  = '0;
        col_d = '0;
      end else if (tx_q == T_MAX) begin
        tx_d  = '0;
        col_d = col_q + 2'd1;
      end else begin
        tx_d  = tx_q + 7'd1;
      end
    end

    ty_d  = ty_q;
    row_d = row_q;
    if (h_wrap) begin
      if (v == Y0M1) begin
        ty_d  = '0;
        row_d = '0;
      end else if (ty_q == T_MAX) begin
        ty_d  = '0;
        row_d = row_q + 2'd1;
      end else begin
        ty_d  = ty_q + 7'd1;
      end
    end

    // The shadow only changes in vertical blanking, so a frame never tears.
    frame_start_d = pix_en && (h == 10'd0) && (v == V_VIS);
    shadow_d      = frame_start_d ? board : shadow_q;

    s1_d   = s1_q;
    addr_d = addr_q;
    if (pix_en) begin
      s1_d.code     = shadow_q[tile_idx * EXP_W +: EXP_W];
      s1_d.in_board = in_board;
      s1_d.visible  = visible;
      s1_d.hs_n     = hs_n;
      s1_d.vs_n     = vs_n;
      addr_d        = in_board ? row_base + 19'(tx_q) : '0;
    end

    case (s1_q.code)
      4'd0:    tile_pix = signal0;
      4'd1:    tile_pix = signal1;
      4'd2:    tile_pix = signal2;
      4'd3:    tile_pix = signal3;
      4'd4:    tile_pix = signal4;
      4'd5:    tile_pix = signal5;
      4'd6:    tile_pix = signal6;
      4'd7:    tile_pix = signal7;
      4'd8:    tile_pix = signal8;
      4'd9:    tile_pix = signal9;
      4'd10:   tile_pix = signal10;
      default: tile_pix = signal11;
    endcase

    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      rgb_d   = !s1_q.visible ? 12'h000 : !s1_q.in_board ? BORDER_RGB : tile_pix;
      hsync_d = s1_q.hs_n;
      vsync_d = s1_q.vs_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q          <= '0;
      ty_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      shadow_q      <= '0;
      frame_start_q <= 1'b0;
      s1_q          <= STAGE1_RST;
      addr_q        <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      tx_q          <= tx_d;
      ty_q          <= ty_d;
      col_q         <= col_d;
      row_q         <= row_d;
      shadow_q      <= shadow_d;
      frame_start_q <= frame_start_d;
      s1_q          <= s1_d;
      addr_q        <= addr_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign pixel_addr  = addr_q;
  assign vga_rgb     = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - scoreboard bench for tile_renderer scan-out
module tb_tile_renderer;

  localparam int          CLK_DIV = 2;
  localparam logic [11:0] BORDER  = 12'h333;
  localparam logic [63:0] BOARD_B = 64'hD987_65A4_F2C1_BE30;

  typedef struct {
    logic        chk;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] board = '0;
  logic [11:0] sig [12];
  logic [18:0] pixel_addr;
  logic [11:0] vga_rgb;
  logic        hsync, vsync, frame_start;

  int          n_vec = 0;
  int          n_bad = 0;
  int          bh = 0;
  int          bv = 0;
  logic [63:0] m_shadow = '0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  tile_renderer #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .board       (board),
    .signal0     (sig[0]),
    .signal1     (sig[1]),
    .signal2     (sig[2]),
    .signal3     (sig[3]),
    .signal4     (sig[4]),
    .signal5     (sig[5]),
    .signal6     (sig[6]),
    .signal7     (sig[7]),
    .signal8     (sig[8]),
    .signal9     (sig[9]),
    .signal10    (sig[10]),
    .signal11    (sig[11]),
    .pixel_addr  (pixel_addr),
    .vga_rgb     (vga_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", tag, got, exp, bh, bv);
    end
  endtask

  function automatic bit chk_line(input int v);
    return v inside {0, 39, 40, 41, 42, 50, 139, 140, 239, 240, 300, 439, 440,
                     479, 480, 481, 489, 490, 491, 492, 500, 524};
  endfunction

  function automatic bit chk_col(input int h);
    return h inside {0, 50, 119, 120, 121, 219, 220, 225, 319, 320, 419, 420,
                     519, 520, 639, 640, 655, 656, 700, 751, 752, 799};
  endfunction

  function automatic bit in_brd(input int h, input int v);
    return (h >= 120) && (h < 520) && (v >= 40) && (v < 440);
  endfunction

  function automatic logic [18:0] exp_addr(input int h, input int v);
    return in_brd(h, v) ? 19'(((v - 40) % 100) * 100 + (h - 120) % 100) : 19'd0;
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v);
    int         t;
    logic [3:0] c;
    if (!(h < 640 && v < 480)) return 12'h000;
    if (!in_brd(h, v)) return BORDER;
    t = ((v - 40) / 100) * 4 + (h - 120) / 100;
    c = m_shadow[4*t +: 4];
    return (c > 4'd11) ? sig[11] : sig[c];
  endfunction

  // After reset the pins first show one pixel of reset-valued stage-1 data.
  task automatic restart_model();
    bh = 0;
    bv = 0;
    m_shadow = '0;
    sb_q.delete();
    sb_q.push_back('{chk: 1'b1, rgb: 12'h000, hs: 1'b1, vs: 1'b1});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check_eq("rst_addr", 32'(pixel_addr), 32'd0);
      check_eq("rst_rgb", 32'(vga_rgb), 32'd0);
      check_eq("rst_hsync", 32'(hsync), 32'd1);
      check_eq("rst_vsync", 32'(vsync), 32'd1);
      check_eq("rst_frame_start", 32'(frame_start), 32'd0);
    end
    rst = 1'b0;
    restart_model();
  endtask

  task automatic step_pixel();
    exp_t e;
    bit   c;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    c = chk_line(bv) || chk_col(bh);
    sb_q.push_back('{chk: c, rgb: exp_rgb(bh, bv),
                     hs: !(bh >= 656 && bh < 752), vs: !(bv >= 490 && bv < 492)});
    if (c) begin
      check_eq("pixel_addr", 32'(pixel_addr), 32'(exp_addr(bh, bv)));
      check_eq("frame_start", 32'(frame_start), 32'(bh == 0 && bv == 480));
    end
    if (sb_q.size() > 1) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        check_eq("vga_rgb", 32'(vga_rgb), 32'(e.rgb));
        check_eq("hsync", 32'(hsync), 32'(e.hs));
        check_eq("vsync", 32'(vsync), 32'(e.vs));
      end
    end
    if (bh == 0 && bv == 480) m_shadow = board;
    bh++;
    if (bh == 800) begin
      bh = 0;
      bv = (bv == 524) ? 0 : bv + 1;
    end
  endtask

  task automatic run_pixels(input int n);
    for (int i = 0; i < n; i++) step_pixel();
  endtask

  initial begin
    for (int i = 0; i < 12; i++) sig[i] = 12'h801 + 12'(i * 16);
    sig[0] = 12'h0A0;
    sig[3] = 12'hF00;

    do_reset(4);
    run_pixels(800 * 200);
    board = BOARD_B;
    run_pixels(800 * 525);
    run_pixels(800 * 100 + 400);
    do_reset(3);
    run_pixels(800 * 483);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
